truth_sweep_ctrl: RTL and testbench
===================================

# truth_sweep_ctrl

Sequential stimulus-and-capture stage for the team's combinational gate exercises. It walks every N_IN-bit input combination onto `vec_out`, which drives the a/b/c inputs of two candidate implementations (for example the reference expression and its NAND/NOR rewrite). After a settle delay it samples both function outputs and emits one result row per combination over a valid/ready handshake. It keeps a mismatch count, records the first mismatching index, and reports whether the two implementations are equivalent, replacing the hand-written `for` loops in the test benches.

## Interface
- `N_IN`, default 3: number of function inputs; sweep length is 2^N_IN.
- `SETTLE`, default 1: cycles to wait after driving `vec_out` before sampling; legal range ≥1.

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `start`  in  1  begin sweep; sampled only in IDLE or DONE
- `fa_in`  in  1  output of implementation A
- `fb_in`  in  1  output of implementation B
- `row_ready`  in  1  consumer accepts the current row
- `vec_out`  out  N_IN  current input combination; {a,b,c} = vec_out, MSB = a
- `busy`  out  1  high from DRIVE through EMIT
- `row_valid`  out  1  result row available
- `row_idx`  out  N_IN  index of the row
- `row_fa`, `row_fb`  out  1 each  sampled outputs
- `mismatch_cnt`  out  N_IN+1  number of rows with row_fa≠row_fb
- `first_mm_valid`  out  1  at least one mismatch recorded
- `first_mm_idx`  out  N_IN  index of the first mismatch
- `done`  out  1  sweep complete, held high in DONE
- `equiv`  out  1  done && mismatch_cnt==0

## Operation
- States: IDLE, DRIVE, SETTLE, EMIT, DONE.
- IDLE or DONE with `start`=1 goes to DRIVE. On entry, idx=0 and mismatch_cnt, first_mm_valid and first_mm_idx are cleared.
- DRIVE (1 cycle): vec_out=idx; the settle counter is loaded with SETTLE-1. Next state is SETTLE.
- SETTLE (SETTLE cycles): the counter decrements. On the cycle it reads 0, fa_in/fb_in are registered into row_fa/row_fb, row_idx is set to idx, and the next state is EMIT.
- EMIT: row_valid=1. Row fields stay stable until `row_valid && row_ready`. On that handshake:
  - mismatch_cnt increments if row_fa≠row_fb.
  - If this is the first mismatch, first_mm_idx=row_idx and first_mm_valid=1.
  - If idx==2^N_IN−1, next state is DONE; otherwise idx+1 and next state is DRIVE.
- idx is N_IN+1 bits internally, so the last-index compare never wraps. vec_out is idx[N_IN-1:0].
- mismatch_cnt maximum is 2^N_IN, which fits in N_IN+1 bits, so there is no saturation.
- `start` in DRIVE/SETTLE/EMIT is ignored.
- vec_out holds its value in EMIT and DONE. In DONE it holds 2^N_IN−1.

## Timing
- Reset values: state IDLE; vec_out, row_idx, row_fa, row_fb, mismatch_cnt, first_mm_idx all 0; busy, row_valid, first_mm_valid, done, equiv all 0.
- Reset mid-sweep aborts immediately, with no row emitted, and returns to reset values.
- Row period with row_ready tied high is 2+SETTLE cycles (3 at the defaults).
- `start` sampled at edge k leads to DONE at edge k+(2+SETTLE)·2^N_IN, which is k+24 at the defaults.
- row_valid rises the cycle after the sample edge. It must never drop without a handshake.
- row_valid and mismatch_cnt update at the same edge as the handshake. mismatch_cnt therefore reflects accepted rows only.
- done/equiv are valid from DONE entry until the next `start` is accepted.

## Structure
- Package `truth_sweep_pkg`: state enum (IDLE/DRIVE/SETTLE/EMIT/DONE) and a default-parameter constant.
- One natural sub-module, `settle_timer`: loadable down-counter with a zero flag, sized $clog2(SETTLE)+1.
- Everything else (FSM, index, row registers, statistics) lives in the top module.

## Test plan
- Both inputs driven by (a'+b·c)' and its NAND/NOR equivalent, row_ready=1 → rows 0..7 give fa=fb=0,0,0,0,1,1,1,0; done at +24 cycles; mismatch_cnt=0; equiv=1.
- fb_in = fa_in XOR (vec_out==5) → mismatch_cnt=1, first_mm_valid=1, first_mm_idx=5, equiv=0.
- fb_in = ~fa_in → mismatch_cnt=8, first_mm_idx=0.
- row_ready low for 10 cycles while row_idx=2 → row_valid stays high; row_idx=2, vec_out=2 and row_fa stable; mismatch_cnt unchanged until the handshake.
- rst_n pulsed low during row 4 → all outputs return to reset values asynchronously. A new `start` restarts at idx 0. `start` pulsed during busy is ignored (row order unchanged).
- N_IN=2, SETTLE=3 → 4 rows, 5-cycle period, done at +20 cycles, mismatch_cnt is 3 bits wide.

Source files
------------

// File: rtl/truth_sweep_pkg.sv
// rtl/truth_sweep_pkg.sv - shared types and defaults for the truth-table sweep controller
package truth_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_EMIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int DEFAULT_N_IN   = 3;
  localparam int DEFAULT_SETTLE = 1;

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter with a zero flag for the settle delay
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;
  localparam logic [W-1:0] ONE = 1;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/truth_sweep_ctrl.sv
// rtl/truth_sweep_ctrl.sv - walks every input combination, samples two candidate
// implementations after a settle delay and streams one compared row per combination
module truth_sweep_ctrl
  import truth_sweep_pkg::*;
#(
  parameter int N_IN   = DEFAULT_N_IN,
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            fa_in,
  input  logic            fb_in,
  input  logic            row_ready,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            row_valid,
  output logic [N_IN-1:0] row_idx,
  output logic            row_fa,
  output logic            row_fb,
  output logic [N_IN:0]   mismatch_cnt,
  output logic            first_mm_valid,
  output logic [N_IN-1:0] first_mm_idx,
  output logic            done,
  output logic            equiv
);

  localparam int            TW       = $clog2(SETTLE) + 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(SETTLE - 1);
  localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'((1 << N_IN) - 1);
  localparam logic [N_IN:0] ONE      = 1;

  state_e          state_q, state_d;
  logic [N_IN:0]   idx_q, idx_d;
  logic [N_IN-1:0] row_idx_q, row_idx_d;
  logic            row_fa_q, row_fa_d;
  logic            row_fb_q, row_fb_d;
  logic [N_IN:0]   mm_cnt_q, mm_cnt_d;
  logic            first_v_q, first_v_d;
  logic [N_IN-1:0] first_idx_q, first_idx_d;

  logic start_ok, settled, sample, handshake, last_row;

  settle_timer #(.W(TW)) u_settle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (state_q == ST_DRIVE),
    .load_val_i(LOAD_VAL),
    .dec_i     (state_q == ST_SETTLE),
    .zero_o    (settled)
  );

  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign sample    = (state_q == ST_SETTLE) && settled;
  assign handshake = (state_q == ST_EMIT) && row_ready;
  // idx carries one extra bit so the last-row compare cannot alias after wrap
  assign last_row  = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_ok) state_d = ST_DRIVE;
      ST_DRIVE:         state_d = ST_SETTLE;
      ST_SETTLE:        if (settled) state_d = ST_EMIT;
      ST_EMIT:          if (handshake) state_d = last_row ? ST_DONE : ST_DRIVE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    row_valid = 1'b0;
    done      = 1'b0;
    equiv     = 1'b0;
    case (state_q)
      ST_DRIVE, ST_SETTLE: busy = 1'b1;
      ST_EMIT: begin
        busy      = 1'b1;
        row_valid = 1'b1;
      end
      ST_DONE: begin
        done  = 1'b1;
        equiv = (mm_cnt_q == '0);
      end
      default: ;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    row_idx_d   = row_idx_q;
    row_fa_d    = row_fa_q;
    row_fb_d    = row_fb_q;
    mm_cnt_d    = mm_cnt_q;
    first_v_d   = first_v_q;
    first_idx_d = first_idx_q;
    if (start_ok) begin
      idx_d       = '0;
      mm_cnt_d    = '0;
      first_v_d   = 1'b0;
      first_idx_d = '0;
    end
    if (sample) begin
      row_idx_d = idx_q[N_IN-1:0];
      row_fa_d  = fa_in;
      row_fb_d  = fb_in;
    end
    // statistics only move on an accepted row, never while the consumer stalls
    if (handshake) begin
      if (row_fa_q != row_fb_q) begin
        mm_cnt_d = mm_cnt_q + ONE;
        if (!first_v_q) begin
          first_v_d   = 1'b1;
          first_idx_d = row_idx_q;
        end
      end
      if (!last_row) idx_d = idx_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      row_idx_q   <= '0;
      row_fa_q    <= 1'b0;
      row_fb_q    <= 1'b0;
      mm_cnt_q    <= '0;
      first_v_q   <= 1'b0;
      first_idx_q <= '0;
    end else begin
      idx_q       <= idx_d;
      row_idx_q   <= row_idx_d;
      row_fa_q    <= row_fa_d;
      row_fb_q    <= row_fb_d;
      mm_cnt_q    <= mm_cnt_d;
      first_v_q   <= first_v_d;
      first_idx_q <= first_idx_d;
    end
  end

  assign vec_out        = idx_q[N_IN-1:0];
  assign row_idx        = row_idx_q;
  assign row_fa         = row_fa_q;
  assign row_fb         = row_fb_q;
  assign mismatch_cnt   = mm_cnt_q;
  assign first_mm_valid = first_v_q;
  assign first_mm_idx   = first_idx_q;

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// tb/tb_truth_sweep_ctrl.sv - directed bench for truth_sweep_ctrl at default and N_IN=2/SETTLE=3
module tb_truth_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start, row_ready, fa, fb;
  logic [2:0] vec, row_idx, first_mm_idx;
  logic [3:0] mm_cnt;
  logic       busy, row_valid, row_fa, row_fb, first_mm_valid, done, equiv;
  int         mode;

  logic a, b, c, fb_nn;
  assign {a, b, c} = vec;
  assign fa    = ~(~a | (b & c));
  assign fb_nn = ~(~(a & a) | ~(~(b & c)));

  always_comb begin
    case (mode)
      0:       fb = fb_nn;
      1:       fb = fb_nn ^ (vec == 3'd5);
      default: fb = ~fb_nn;
    endcase
  end

  truth_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fa_in(fa), .fb_in(fb),
    .row_ready(row_ready), .vec_out(vec), .busy(busy), .row_valid(row_valid),
    .row_idx(row_idx), .row_fa(row_fa), .row_fb(row_fb), .mismatch_cnt(mm_cnt),
    .first_mm_valid(first_mm_valid), .first_mm_idx(first_mm_idx),
    .done(done), .equiv(equiv)
  );

  logic       start2, fa2, fb2, busy2, rv2, rfa2, rfb2, fmv2, done2, equiv2;
  logic [1:0] vec2, ridx2, fmi2;
  logic [2:0] mm2;
  assign fa2 = vec2[1] ^ vec2[0];
  assign fb2 = ~fa2;

  truth_sweep_ctrl #(.N_IN(2), .SETTLE(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .fa_in(fa2), .fb_in(fb2),
    .row_ready(1'b1), .vec_out(vec2), .busy(busy2), .row_valid(rv2),
    .row_idx(ridx2), .row_fa(rfa2), .row_fb(rfb2), .mismatch_cnt(mm2),
    .first_mm_valid(fmv2), .first_mm_idx(fmi2), .done(done2), .equiv(equiv2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [2:0] r_idx [16];
  logic       r_fa  [16];
  logic       r_fb  [16];
  int         n_rows;
  int         cyc;
  logic [7:0] fa_tab;

  task automatic run_sweep(input bit poke);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    n_rows = 0;
    while (cyc < 300) begin
      @(negedge clk);
      start = (poke && cyc == 4);
      if (row_valid && row_ready && n_rows < 16) begin
        r_idx[n_rows] = row_idx;
        r_fa[n_rows]  = row_fa;
        r_fb[n_rows]  = row_fb;
        n_rows++;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic check_rows(input string tag, input int fb_mode);
    logic exp_fb;
    check_eq({tag, "_nrows"}, n_rows, 8);
    for (int i = 0; i < 8; i++) begin
      exp_fb = (fb_mode == 0) ? fa_tab[i] : ~fa_tab[i];
      check_eq($sformatf("%s_idx%0d", tag, i), 32'(r_idx[i]), i);
      check_eq($sformatf("%s_fa%0d", tag, i), 32'(r_fa[i]), 32'(fa_tab[i]));
      check_eq($sformatf("%s_fb%0d", tag, i), 32'(r_fb[i]), 32'(exp_fb));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_vec"}, 32'(vec), 0);
    check_eq({tag, "_row_idx"}, 32'(row_idx), 0);
    check_eq({tag, "_row_fa_fb"}, 32'({row_fa, row_fb}), 0);
    check_eq({tag, "_mm_cnt"}, 32'(mm_cnt), 0);
    check_eq({tag, "_first_mm"}, 32'({first_mm_valid, first_mm_idx}), 0);
    check_eq({tag, "_flags"}, 32'({busy, row_valid, done, equiv}), 0);
  endtask

  logic       hold_fa;
  logic [3:0] hold_mm;
  int         t;

  initial begin
    fa_tab    = 8'b0111_0000;
    start     = 1'b0;
    start2    = 1'b0;
    row_ready = 1'b1;
    mode      = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;

    // equivalent implementations
    run_sweep(1'b0);
    check_eq("equiv_cycles", cyc, 24);
    check_rows("equiv", 0);
    check_eq("equiv_mm", 32'(mm_cnt), 0);
    check_eq("equiv_fmv", 32'(first_mm_valid), 0);
    check_eq("equiv_done_eq", 32'({done, equiv}), 32'b11);
    check_eq("equiv_vec_done", 32'(vec), 7);

    // single mismatch at index 5
    mode = 1;
    run_sweep(1'b0);
    check_eq("one_cycles", cyc, 24);
    check_eq("one_mm", 32'(mm_cnt), 1);
    check_eq("one_first", 32'({first_mm_valid, first_mm_idx}), 32'h0d);
    check_eq("one_done_eq", 32'({done, equiv}), 32'b10);

    // every row mismatches
    mode = 2;
    run_sweep(1'b0);
    check_rows("inv", 1);
    check_eq("inv_mm", 32'(mm_cnt), 8);
    check_eq("inv_first", 32'({first_mm_valid, first_mm_idx}), 32'h08);
    check_eq("inv_equiv", 32'(equiv), 0);

    // consumer stall on row 2
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    t = 0;
    while (t < 100) begin
      @(negedge clk);
      t++;
      if (row_valid && row_idx == 3'd2) break;
    end
    check_eq("stall_found", 32'(row_valid && row_idx == 3'd2), 1);
    row_ready = 1'b0;
    hold_fa = row_fa;
    hold_mm = mm_cnt;
    check_eq("stall_mm_pre", 32'(mm_cnt), 2);
    repeat (10) begin
      @(negedge clk);
      check_eq("stall_valid", 32'(row_valid), 1);
      check_eq("stall_idx", 32'(row_idx), 2);
      check_eq("stall_vec", 32'(vec), 2);
      check_eq("stall_fa", 32'(row_fa), 32'(hold_fa));
      check_eq("stall_mm", 32'(mm_cnt), 32'(hold_mm));
    end
    row_ready = 1'b1;
    @(posedge clk) #1;
    check_eq("stall_mm_post", 32'(mm_cnt), 3);
    check_eq("stall_valid_post", 32'(row_valid), 0);
    t = 0;
    while (!done && t < 100) begin
      @(posedge clk) #1;
      t++;
    end
    check_eq("stall_final_mm", 32'(mm_cnt), 8);

    // asynchronous reset during row 4, then restart with start poked while busy
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    t = 0;
    while (t < 100) begin
      @(negedge clk);
      t++;
      if (row_valid && row_idx == 3'd4) break;
    end
    check_eq("rst_mid_mm", 32'(mm_cnt), 4);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge clk) rst_n = 1'b1;
    mode = 0;
    run_sweep(1'b1);
    check_eq("restart_cycles", cyc, 24);
    check_rows("restart", 0);
    check_eq("restart_equiv", 32'(equiv), 1);

    // N_IN=2, SETTLE=3 instance, all rows mismatch
    @(negedge clk) start2 = 1'b1;
    @(posedge clk) #1 start2 = 1'b0;
    cyc = 0;
    n_rows = 0;
    while (cyc < 300) begin
      @(negedge clk);
      if (rv2) begin
        check_eq($sformatf("n2_idx%0d", n_rows), 32'(ridx2), n_rows);
        n_rows++;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (done2) break;
    end
    check_eq("n2_cycles", cyc, 20);
    check_eq("n2_nrows", n_rows, 4);
    check_eq("n2_mm", 32'(mm2), 4);
    check_eq("n2_first", 32'({fmv2, fmi2}), 32'h4);
    check_eq("n2_equiv", 32'(equiv2), 0);
    check_eq("n2_vec", 32'(vec2), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
